// File: rtl/dsq_scan_ctrl.sv
// rtl/dsq_scan_ctrl.sv - nearest-neighbour scan sequencer for the 4-lane byte SSD datapath
//
// Holds DEPTH packed 4x8-bit reference words and streams the first cfg_count
// of them, one per accepted datapath handshake, against a latched query word.
// Keeps the minimum SSD seen and the index where it was first found.
//
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   ld_valid/ld_idx/ld_data reference bank write (accepted while ld_ready)
//   ld_ready                high whenever no scan is in progress
//   cfg_count, query, start scan length (clamped to DEPTH) and query word, sampled on start
//   busy, done              scan in progress / one-cycle completion pulse
//   found, best_dist, best_idx  result of the last scan, held until next start
//   dp_rs1/dp_rs2/dp_valid  request to the SSD datapath
//   dp_ready/dp_rd          datapath result strobe and SSD value
module dsq_scan_ctrl #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ld_valid,
    input  logic [IDX_W-1:0] ld_idx,
    input  logic [31:0]      ld_data,
    output logic             ld_ready,
    input  logic [IDX_W:0]   cfg_count,
    input  logic             start,
    input  logic [31:0]      query,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [31:0]      best_dist,
    output logic [IDX_W-1:0] best_idx,
    output logic [31:0]      dp_rs1,
    output logic [31:0]      dp_rs2,
    output logic             dp_valid,
    input  logic             dp_ready,
    input  logic [31:0]      dp_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W:0]   DEPTH_C = (IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W:0]   CNT_ONE = (IDX_W + 1)'(1);
    localparam logic [IDX_W-1:0] PTR_ONE = IDX_W'(1);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   cnt_q;
    logic [31:0]      query_q;
    logic [31:0]      bank [DEPTH];

    logic [IDX_W:0]   cnt_clamped;
    logic             last_entry;

    always_comb begin
        cnt_clamped = (cfg_count > DEPTH_C) ? DEPTH_C : cfg_count;
        last_entry  = ({1'b0, ptr} == (cnt_q - CNT_ONE));
    end

    // busy is a registered copy of "state == SCAN", so the datapath request
    // and the load handshake are decoded from flops, not from next-state logic.
    assign ld_ready = !busy;
    assign dp_valid = busy;
    assign dp_rs1   = busy ? query_q   : 32'd0;
    assign dp_rs2   = busy ? bank[ptr] : 32'd0;

    // Bank is intentionally left out of reset. A load on the same edge as a
    // start lands before the first SCAN cycle reads it.
    always_ff @(posedge clk) begin
        if (ld_valid && !busy) begin
            bank[ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            best_dist <= 32'hFFFF_FFFF;
            best_idx  <= '0;
            ptr       <= '0;
            cnt_q     <= '0;
            query_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        query_q   <= query;
                        cnt_q     <= cnt_clamped;
                        best_dist <= 32'hFFFF_FFFF;
                        best_idx  <= '0;
                        found     <= 1'b0;
                        ptr       <= '0;
                        if (cnt_clamped != '0) begin
                            state <= SCAN;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (dp_ready) begin
                        // Strict compare: on a tie the earlier index wins.
                        if (dp_rd < best_dist) begin
                            best_dist <= dp_rd;
                            best_idx  <= ptr;
                        end
                        found <= 1'b1;
                        if (last_entry) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            ptr <= ptr + PTR_ONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
